window_gen: RTL and testbench

Streaming 3×3 window generator for the convolution datapath. Accepts one fixed-point pixel per cycle in raster order and emits every fully-populated 3×3 neighbourhood (valid convolution, no padding), packed in the 9-element format consumed by the inner-product unit. Sits between the feature-map source and the inner-product stage; its `win` and `win_valid` drive that stage's `d1` and `load` inputs directly.

---
 rtl/window_gen_pkg.sv | 14 +
 rtl/line_buffer.sv | 28 ++
 rtl/window_gen.sv | 107 ++++++++++
 tb/tb_window_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/window_gen_pkg.sv
// rtl/window_gen_pkg.sv - shared constants and helpers for the 3x3 window generator
package window_gen_pkg;

  localparam int DEF_DATA_LEN = 16;

  localparam int WIN_DIM = 3;
  localparam int WIN_N   = WIN_DIM * WIN_DIM;

  // Flat element index inside the packed window: row-major, top-left oldest.
  function automatic int win_idx(input int r, input int c);
    return WIN_DIM * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - DEPTH-deep enabled shift register delaying a pixel stream by one image row
module line_buffer
  import window_gen_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= d;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign q = mem[DEPTH-1];

endmodule

// File: rtl/window_gen.sv
// rtl/window_gen.sv - streaming 3x3 window generator for the convolution datapath
// Raster-order pixels in, every fully-populated 3x3 neighbourhood out, no padding.
module window_gen
  import window_gen_pkg::*;
#(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int DATA_LEN = DEF_DATA_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_LEN-1:0]       in_data,
  output logic [WIN_N*DATA_LEN-1:0] win,
  output logic                      win_valid,
  output logic                      frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic                col_last;
  logic                row_last;
  logic                full_window;
  logic [DATA_LEN-1:0] lb1_q;
  logic [DATA_LEN-1:0] lb2_q;
  logic [DATA_LEN-1:0] win_r [WIN_DIM][WIN_DIM];

  assign col_last    = (col == COL_LAST);
  assign row_last    = (row == ROW_LAST);
  // Only neighbourhoods lying entirely inside the image count; the window
  // still shifts on every pixel, so row-straddling contents are simply not flagged.
  assign full_window = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_LEN)
  ) u_lb1 (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .d   (in_data),
    .q   (lb1_q)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_LEN)
  ) u_lb2 (
    .clk (clk),
    .rst (rst),
    .en  (in_valid),
    .d   (lb1_q),
    .q   (lb2_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < WIN_DIM; r++)
        for (int c = 0; c < WIN_DIM; c++)
          win_r[r][c] <= '0;
    end else if (in_valid) begin
      for (int r = 0; r < WIN_DIM; r++)
        for (int c = 0; c < WIN_DIM - 1; c++)
          win_r[r][c] <= win_r[r][c+1];
      win_r[0][WIN_DIM-1] <= lb2_q;
      win_r[1][WIN_DIM-1] <= lb1_q;
      win_r[2][WIN_DIM-1] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= in_valid && full_window;
      frame_done <= in_valid && row_last && col_last;
    end
  end

  for (genvar r = 0; r < WIN_DIM; r++) begin : g_row
    for (genvar c = 0; c < WIN_DIM; c++) begin : g_col
      assign win[win_idx(r, c)*DATA_LEN +: DATA_LEN] = win_r[r][c];
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - self-checking bench for window_gen on a 4x4 frame
module tb_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DL = 16;
  localparam int WL = 9 * DL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DL-1:0] in_data = '0;
  logic [WL-1:0] win;
  logic          win_valid;
  logic          frame_done;

  always #5 clk = ~clk;

  window_gen #(
    .IMG_W    (W),
    .IMG_H    (H),
    .DATA_LEN (DL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .win        (win),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [DL-1:0] pix;
    logic          v;
    logic          d;
    int            tl;
  } vec_t;

  vec_t tbl [16];
  int   total = 0;
  int   bad   = 0;

  logic [DL-1:0] img [H][W];
  int            m_row   = 0;
  int            m_col   = 0;
  logic          m_valid = 1'b0;
  logic          m_done  = 1'b0;
  logic          m_known = 1'b1;
  logic [WL-1:0] m_win   = '0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 3x3 neighbourhood of a 4-wide integer ramp whose top-left pixel is tl.
  function automatic logic [WL-1:0] ramp_win(input int tl);
    logic [WL-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DL +: DL] = DL'(tl + (k / 3) * W + (k % 3));
    return w;
  endfunction

  function automatic logic [WL-1:0] window_at(input int r, input int c);
    logic [WL-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DL +: DL] = img[r-2+k/3][c-2+k%3];
    return w;
  endfunction

  // Drive one cycle, advance the reference image model, check outputs after the edge.
  task automatic step(input logic v, input logic [DL-1:0] d, input logic r);
    rst      = r;
    in_valid = v;
    in_data  = d;
    if (r) begin
      m_row = 0; m_col = 0; m_valid = 0; m_done = 0; m_known = 1; m_win = '0;
    end else if (v) begin
      img[m_row][m_col] = d;
      m_valid = (m_row >= 2) && (m_col >= 2);
      m_done  = (m_row == H - 1) && (m_col == W - 1);
      if (m_valid) begin
        m_win   = window_at(m_row, m_col);
        m_known = 1;
      end else begin
        m_known = 0;
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end else begin
      m_valid = 0;
      m_done  = 0;
    end
    @(posedge clk);
    #1;
    chk1("model_win_valid", win_valid, m_valid);
    chk1("model_frame_done", frame_done, m_done);
    if (m_known) chkw("model_win", win, m_win);
  endtask

  task automatic run_table(input int base, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DL'(base) + tbl[i].pix, 1'b0);
      chk1($sformatf("tbl_win_valid[%0d]", i), win_valid, tbl[i].v);
      chk1($sformatf("tbl_frame_done[%0d]", i), frame_done, tbl[i].d);
      if (tbl[i].v) chkw($sformatf("tbl_win[%0d]", i), win, ramp_win(tbl[i].tl + base));
      if (gaps) begin
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
      end
    end
  endtask

  logic [DL-1:0] vals [3];

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].pix = DL'(i);
      tbl[i].v   = 1'b0;
      tbl[i].d   = 1'b0;
      tbl[i].tl  = 0;
    end
    tbl[10].v = 1'b1; tbl[10].tl = 0;
    tbl[11].v = 1'b1; tbl[11].tl = 1;
    tbl[14].v = 1'b1; tbl[14].tl = 4;
    tbl[15].v = 1'b1; tbl[15].tl = 5;
    tbl[15].d = 1'b1;
    vals[0] = 16'h8000;
    vals[1] = 16'h7fff;
    vals[2] = 16'hffff;

    // Reset state
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chkw("reset_win_zero", win, '0);
    step(1'b0, '0, 1'b0);

    // Basic frame, then a back-to-back second frame
    run_table(0, 1'b0);
    run_table(100, 1'b0);

    // Same stream with in_valid gaps
    run_table(0, 1'b1);

    // Reset mid-frame; a pixel presented with reset is dropped
    for (int i = 0; i < 7; i++) step(1'b1, DL'(i), 1'b0);
    step(1'b1, DL'(99), 1'b1);
    step(1'b0, '0, 1'b0);
    run_table(0, 1'b0);

    // Full-range signed data, bit-exact
    for (int i = 0; i < 16; i++) step(1'b1, vals[i % 3], 1'b0);
    chkw("signed_elem8", WL'(win[8*DL +: DL]), WL'(vals[0]));
    chkw("signed_elem0", WL'(win[0 +: DL]), WL'(vals[2]));
    chkw("signed_elem4", WL'(win[4*DL +: DL]), WL'(vals[1]));

    // Randomised stream with sparse valids and occasional resets
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           DL'($urandom),
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    // Random full-range frame from a clean start
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, vals[$urandom_range(0, 2)], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
